// File: rtl/bp_me_io_cmd_arbiter.sv
// Round-robin arbiter that shares one IO command link among several masters
// and routes in-order responses back to the master that issued each command.
module bp_me_io_cmd_arbiter #(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_i,

  input  logic [num_req_p*msg_width_p-1:0]   io_cmd_i,
  input  logic [num_req_p-1:0]               io_cmd_v_i,
  output logic [num_req_p-1:0]               io_cmd_ready_o,

  output logic [msg_width_p-1:0]             io_cmd_o,
  output logic                               io_cmd_v_o,
  input  logic                               io_cmd_ready_i,

  input  logic [msg_width_p-1:0]             io_resp_i,
  input  logic                               io_resp_v_i,
  output logic                               io_resp_yumi_o,

  output logic [msg_width_p-1:0]             io_resp_o,
  output logic [num_req_p-1:0]               io_resp_v_o,
  input  logic [num_req_p-1:0]               io_resp_ready_i,

  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
  output logic                               err_o
);

  localparam int id_w  = $clog2(num_req_p);
  localparam int ptr_w = $clog2(max_outstanding_p);
  localparam int cnt_w = $clog2(max_outstanding_p+1);

  logic [msg_width_p-1:0] cmd_arr [num_req_p];

  logic [id_w-1:0]  rr_ptr_reg, rr_ptr_next;
  logic             lock_reg, lock_next;
  logic [id_w-1:0]  lock_id_reg, lock_id_next;
  logic [ptr_w-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ptr_w-1:0] rd_ptr_reg, rd_ptr_next;
  logic [cnt_w-1:0] count_reg, count_next;
  logic             err_reg, err_next;

  // Tiny ID store read asynchronously so the head owner is known in the same cycle.
  logic [id_w-1:0]  id_mem_reg [max_outstanding_p];

  logic [id_w-1:0]  rr_winner;
  logic [id_w-1:0]  grant;
  logic [id_w-1:0]  head;
  logic [id_w:0]    rot_idx;
  logic [id_w:0]    grant_inc;
  logic             found;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (count_reg == cnt_w'(max_outstanding_p));
  assign empty = (count_reg == '0);

  always_comb begin
    rr_winner = rr_ptr_reg;
    found     = 1'b0;
    rot_idx   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      rot_idx = {1'b0, rr_ptr_reg} + (id_w+1)'(i);
      if (rot_idx >= (id_w+1)'(num_req_p))
        rot_idx = rot_idx - (id_w+1)'(num_req_p);
      if (!found && io_cmd_v_i[rot_idx[id_w-1:0]]) begin
        found     = 1'b1;
        rr_winner = rot_idx[id_w-1:0];
      end
    end
  end

  // A stalled grant stays pinned to the same master until the link accepts it.
  assign grant      = lock_reg ? lock_id_reg : rr_winner;
  assign io_cmd_v_o = ~reset_i & ((|io_cmd_v_i) | lock_reg) & ~full;
  assign io_cmd_o   = cmd_arr[grant];
  assign push       = io_cmd_v_o & io_cmd_ready_i;

  assign head           = id_mem_reg[rd_ptr_reg];
  assign io_resp_yumi_o = ~reset_i & io_resp_v_i & ~empty & io_resp_ready_i[head];
  assign pop            = io_resp_yumi_o;
  assign io_resp_o      = io_resp_i;
  assign outstanding_o  = count_reg;
  assign err_o          = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < num_req_p; gi++) begin : g_master
      assign cmd_arr[gi]        = io_cmd_i[gi*msg_width_p +: msg_width_p];
      assign io_cmd_ready_o[gi] = io_cmd_ready_i & io_cmd_v_o & (grant == id_w'(gi));
      assign io_resp_v_o[gi]    = ~reset_i & io_resp_v_i & ~empty & (head == id_w'(gi));
    end
  endgenerate

  always_comb begin
    rr_ptr_next  = rr_ptr_reg;
    lock_next    = lock_reg;
    lock_id_next = lock_id_reg;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    err_next     = err_reg;
    grant_inc    = {1'b0, grant} + (id_w+1)'(1);

    if (io_cmd_v_o && !io_cmd_ready_i) begin
      lock_next    = 1'b1;
      lock_id_next = grant;
    end else if (push) begin
      lock_next    = 1'b0;
    end

    if (push) begin
      rr_ptr_next = (grant_inc == (id_w+1)'(num_req_p)) ? '0 : grant_inc[id_w-1:0];
      wr_ptr_next = wr_ptr_reg + ptr_w'(1);
    end
    if (pop)
      rd_ptr_next = rd_ptr_reg + ptr_w'(1);

    count_next = count_reg + cnt_w'(push) - cnt_w'(pop);

    // A response with nothing in flight has no owner; flag it and leave it unconsumed.
    if (io_resp_v_i && empty)
      err_next = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_reg  <= '0;
      lock_reg    <= 1'b0;
      lock_id_reg <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      rr_ptr_reg  <= rr_ptr_next;
      lock_reg    <= lock_next;
      lock_id_reg <= lock_id_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      err_reg     <= err_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      id_mem_reg[wr_ptr_reg] <= grant;
  end

endmodule
